// File: rtl/alu_pkg.sv
// Shared opcodes, width default and compare result constants for the registered 8-bit ALU.
// Compare signedness is selected at build time by ALU_SIGNED_CMP_EN (see alu8_comb).
package alu_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_LT   = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_NE   = 4'd13;
  localparam logic [3:0] OP_GE   = 4'd14;
  localparam logic [3:0] OP_LE   = 4'd15;

  localparam logic [7:0] TRUE_VAL  = 8'h01;
  localparam logic [7:0] FALSE_VAL = 8'h00;

endpackage

// File: rtl/alu8_comb.sv
// Purely combinational result/flag generator; zero latency; no flow control.
// ALU_SIGNED_CMP_EN defined: LT/GT/GE/LE treat operands as two's complement.
module alu8_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           lt;
  logic           gt;
  logic           eq;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign eq   = (a == b);

`ifdef ALU_SIGNED_CMP_EN
  assign lt = ($signed(a) < $signed(b));
  assign gt = ($signed(a) > $signed(b));
`else
  assign lt = (a < b);
  assign gt = (a > b);
`endif

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (sel)
      OP_ADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        result   = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_NAND: result = ~(a & b);
      OP_XNOR: result = ~(a ^ b);
      OP_LT:   result = lt          ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      OP_EQ:   result = eq          ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      OP_GT:   result = gt          ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      OP_NE:   result = !eq         ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      OP_GE:   result = !lt         ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      OP_LE:   result = (lt || eq)  ? WIDTH'(TRUE_VAL) : WIDTH'(FALSE_VAL);
      default: begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu8_core_reg.sv
// Registered 8-bit, 16-function ALU; build option ALU_SIGNED_CMP_EN selects signed compares.
// Latency 1 clock from in_valid to out_valid; no backpressure, outputs hold while in_valid=0.
module alu8_core_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;
  logic             core_overflow;

  alu8_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a        (A),
    .b        (B),
    .sel      (ALU_Sel),
    .result   (core_result),
    .carry    (core_carry),
    .zero     (core_zero),
    .overflow (core_overflow)
  );

  // Reset wins over capture; results and flags only update on a valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out  <= core_result;
        CarryOut <= core_carry;
        Zero     <= core_zero;
        Overflow <= core_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu8_core_reg.sv
// Directed scoreboard bench for alu8_core_reg; expected results come from an arithmetic model.
module tb_alu8_core_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [3:0] ALU_Sel = 4'h0;
  logic [7:0] ALU_Out;
  logic       CarryOut;
  logic       Zero;
  logic       Overflow;
  logic       out_valid;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu8_core_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .ALU_Out   (ALU_Out),
    .CarryOut  (CarryOut),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .out_valid (out_valid)
  );

  function automatic int sval(input logic [7:0] x);
`ifdef ALU_SIGNED_CMP_EN
    return x[7] ? int'(x) - 256 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia, ib, s;
    ia = int'(a);
    ib = int'(b);
    e = '0;
    case (op)
      4'd0: begin
        s = ia + ib;
        e.r = s[7:0];
        e.c = (s > 255);
        e.v = (a[7] == b[7]) && (e.r[7] != a[7]);
      end
      4'd1: begin
        s = ia - ib;
        e.r = s[7:0];
        e.c = (ia < ib);
        e.v = (a[7] != b[7]) && (e.r[7] != a[7]);
      end
      4'd2:  e.r = a & b;
      4'd3:  e.r = a | b;
      4'd4:  e.r = a ^ b;
      4'd5:  e.r = ~(a | b);
      4'd6:  begin s = (ia * 2) % 256; e.r = s[7:0]; e.c = (ia >= 128); end
      4'd7:  begin s = ia / 2;         e.r = s[7:0]; e.c = (ia % 2 == 1); end
      4'd8:  e.r = ~(a & b);
      4'd9:  e.r = ~(a ^ b);
      4'd10: e.r = (sval(a) <  sval(b)) ? 8'h01 : 8'h00;
      4'd11: e.r = (ia == ib)           ? 8'h01 : 8'h00;
      4'd12: e.r = (sval(a) >  sval(b)) ? 8'h01 : 8'h00;
      4'd13: e.r = (ia != ib)           ? 8'h01 : 8'h00;
      4'd14: e.r = (sval(a) >= sval(b)) ? 8'h01 : 8'h00;
      default: e.r = (sval(a) <= sval(b)) ? 8'h01 : 8'h00;
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, ".out"},  ALU_Out, e.r);
    chk({tag, ".c"},    {7'b0, CarryOut}, {7'b0, e.c});
    chk({tag, ".z"},    {7'b0, Zero},     {7'b0, e.z});
    chk({tag, ".v"},    {7'b0, Overflow}, {7'b0, e.v});
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; ALU_Sel = op; A = a; B = b;
    if (v && !r) q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, {7'b0, out_valid}, {7'b0, (v && !r)});
    if (r) begin
      held = '0;
      chk_outs(tag, held);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk({tag, ".sb_empty"}, 8'd0, 8'd1);
      end else begin
        e = q.pop_front();
        chk_outs(tag, e);
        held = e;
      end
    end else begin
      chk_outs({tag, ".hold"}, held);
    end
  endtask

  initial begin
    held = '0;
    step("rst0", 1'b1, 1'b1, 4'd0, 8'hFF, 8'h01);
    step("rst1", 1'b1, 1'b1, 4'd0, 8'hFF, 8'h01);

    step("add",   1'b0, 1'b1, 4'd0,  8'hAA, 8'h55);
    step("sub",   1'b0, 1'b1, 4'd1,  8'hAA, 8'h55);
    step("addc",  1'b0, 1'b1, 4'd0,  8'hFF, 8'h01);
    step("addv",  1'b0, 1'b1, 4'd0,  8'h7F, 8'h01);
    step("subb",  1'b0, 1'b1, 4'd1,  8'h10, 8'h20);
    step("subv",  1'b0, 1'b1, 4'd1,  8'h80, 8'h01);
    step("and",   1'b0, 1'b1, 4'd2,  8'hAA, 8'h55);
    step("or",    1'b0, 1'b1, 4'd3,  8'hAA, 8'h55);
    step("xor",   1'b0, 1'b1, 4'd4,  8'hAA, 8'h55);
    step("nor",   1'b0, 1'b1, 4'd5,  8'hAA, 8'h55);
    step("nand",  1'b0, 1'b1, 4'd8,  8'hAA, 8'h55);
    step("xnor",  1'b0, 1'b1, 4'd9,  8'hAA, 8'h55);
    step("shl",   1'b0, 1'b1, 4'd6,  8'hAA, 8'h55);
    step("shr",   1'b0, 1'b1, 4'd7,  8'hAA, 8'h55);
    step("shr1",  1'b0, 1'b1, 4'd7,  8'h01, 8'hFF);
    step("lt",    1'b0, 1'b1, 4'd10, 8'hAA, 8'h55);
    step("eq",    1'b0, 1'b1, 4'd11, 8'hAA, 8'h55);
    step("gt",    1'b0, 1'b1, 4'd12, 8'hAA, 8'h55);
    step("ne",    1'b0, 1'b1, 4'd13, 8'hAA, 8'h55);
    step("ge",    1'b0, 1'b1, 4'd14, 8'hAA, 8'h55);
    step("le",    1'b0, 1'b1, 4'd15, 8'hAA, 8'h55);
    step("eq_t",  1'b0, 1'b1, 4'd11, 8'h3C, 8'h3C);
    step("ge_eq", 1'b0, 1'b1, 4'd14, 8'h3C, 8'h3C);
    step("le_eq", 1'b0, 1'b1, 4'd15, 8'h3C, 8'h3C);

    step("pre",   1'b0, 1'b1, 4'd0,  8'h12, 8'h34);
    step("hold0", 1'b0, 1'b0, 4'd5,  8'h00, 8'h00);
    step("hold1", 1'b0, 1'b0, 4'd1,  8'h01, 8'h02);
    step("resume",1'b0, 1'b1, 4'd6,  8'h81, 8'h00);

    for (int i = 0; i < 24; i++) begin
      step("rnd", 1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    step("pre_rst", 1'b0, 1'b1, 4'd3, 8'hF0, 8'h0F);
    step("mid_rst", 1'b1, 1'b1, 4'd3, 8'hF0, 8'h0F);
    step("post_rst",1'b0, 1'b0, 4'd0, 8'hFF, 8'hFF);

    chk("sb_drain", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
